// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window scheduler.
// Imported by the scheduler top.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        OUT
    } sched_state_t;

    localparam int BURST_LEN   = 9;
    localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/median_line_buf.sv
// One-line pixel buffer: single address per cycle, read returns the
// contents from before a same-cycle write.
module median_line_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Contents are never reset; the row counter guards against stale lines.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window_sched.sv
// Raster scheduler: keeps two line buffers and a 3x3 window, bursts each
// interior window to the median engine and presents the result on a
// valid/ready output.
module median_window_sched
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST,
    output logic [WIDTH-1:0] M_DI,
    output logic             M_DSI,
    input  logic [WIDTH-1:0] M_DO,
    input  logic             M_DSO
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN = CW'(2);
    localparam logic [RW-1:0] ROW_MIN = RW'(2);

    localparam logic [BURST_CNT_W-1:0] K_LAST =
        BURST_CNT_W'(BURST_LEN - 1);

    sched_state_t state_q;
    sched_state_t state_d;

    logic [CW-1:0]          col_q;
    logic [CW-1:0]          col_d;
    logic [RW-1:0]          row_q;
    logic [RW-1:0]          row_d;
    logic [BURST_CNT_W-1:0] k_q;
    logic [BURST_CNT_W-1:0] k_d;

    // Window stored row-major, oldest row first, left column first.
    logic [WIDTH-1:0] win_q [BURST_LEN];
    logic [WIDTH-1:0] win_d [BURST_LEN];

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_last_q;
    logic             out_last_d;
    logic             last_pend_q;
    logic             last_pend_d;

    logic             accept;
    logic             interior;
    logic             col_wrap;
    logic             row_wrap;
    logic             burst_end;
    logic [WIDTH-1:0] lb_a_rd;
    logic [WIDTH-1:0] lb_b_rd;

    assign accept    = (state_q == IDLE) && IN_VALID;
    assign col_wrap  = (col_q == COL_MAX);
    assign row_wrap  = (row_q == ROW_MAX);
    assign interior  = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    assign burst_end = (k_q == K_LAST);

    median_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W)
    ) lb_a (
        .CLK     (CLK),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (IN_DATA),
        .rd_data (lb_a_rd)
    );

    median_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W)
    ) lb_b (
        .CLK     (CLK),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (lb_a_rd),
        .rd_data (lb_b_rd)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && interior) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (burst_end) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (M_DSO) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        k_d         = k_q;
        win_d       = win_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        last_pend_d = last_pend_q;

        if (accept) begin
            col_d = col_wrap ? '0 : col_q + 1'b1;
            if (col_wrap) begin
                row_d = row_wrap ? '0 : row_q + 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
            win_d[2]    = lb_b_rd;
            win_d[5]    = lb_a_rd;
            win_d[8]    = IN_DATA;
            last_pend_d = row_wrap && col_wrap;
        end

        if (state_q == LOAD) begin
            k_d = burst_end ? '0 : k_q + 1'b1;
        end

        // M_DSO only matters while a burst result is outstanding.
        if ((state_q == WAIT) && M_DSO) begin
            out_data_d = M_DO;
            out_last_d = last_pend_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            col_q       <= '0;
            row_q       <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            last_pend_q <= last_pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        win_q <= win_d;
    end

    always_comb begin
        IN_READY  = (state_q == IDLE);
        M_DSI     = (state_q == LOAD);
        OUT_VALID = (state_q == OUT);
        M_DI      = '0;
        if (state_q == LOAD) begin
            M_DI = win_q[k_q];
        end
    end

    assign OUT_DATA = out_data_q;
    assign OUT_LAST = out_last_q;

endmodule

// File: tb/tb_median_window_sched.sv
// Bench for median_window_sched: frame-level model plus a behavioural
// median engine, with directed frames and randomized traffic.
module tb_median_window_sched;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int IH = 4;

    localparam int K_RAMP = 0;
    localparam int K_FF   = 1;
    localparam int K_IMP  = 2;
    localparam int K_RND  = 3;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic [W-1:0] IN_DATA = '0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] OUT_DATA;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b1;
    logic         OUT_LAST;
    logic [W-1:0] M_DI;
    logic         M_DSI;
    logic [W-1:0] M_DO = '0;
    logic         M_DSO = 1'b0;

    always #5 CLK = ~CLK;

    median_window_sched #(
        .WIDTH (W),
        .IMG_W (IW),
        .IMG_H (IH)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .M_DI      (M_DI),
        .M_DSI     (M_DSI),
        .M_DO      (M_DO),
        .M_DSO     (M_DSO)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or item missing", name);
    endtask

    function automatic logic [7:0] med9(input logic [7:0] s [9]);
        logic [7:0] a [9];
        logic [7:0] t;
        a = s;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                end
        return a[4];
    endfunction

    // Frame model state
    logic [7:0] img [IH][IW];
    int         pix_n;
    bit         outstanding;
    bit         out_on;
    int         burst_left;
    logic [7:0] exp_smp [$];
    logic [8:0] exp_out [$];
    bit         rst_pend;
    bit         hold_chk;
    logic [7:0] held_d;
    logic       held_l;
    bit         prev_dsi;

    // Engine model state
    logic [7:0] eng_buf [$];
    int         eng_cnt = -1;

    // Observations for directed checks
    logic [7:0] obs_data [$];
    bit         obs_last [$];
    logic [7:0] obs_burst [$];
    int         burst_cnt;
    int         last_cnt;

    bit abort = 0;
    bit gaps = 0;
    bit rdy_mode = 0;

    logic [7:0] ramp_exp [4] = '{8'd5, 8'd6, 8'd9, 8'd10};
    logic [7:0] ff_exp   [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] imp_exp  [4] = '{8'h20, 8'h20, 8'h20, 8'h20};
    logic [7:0] burst0   [9] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5,
                                 8'd6, 8'd8, 8'd9, 8'd10};

    always @(negedge CLK) begin
        logic [7:0] win [9];
        logic [7:0] eb [9];
        logic [8:0] e;
        logic [7:0] s;
        int r;
        int c;
        if (!nRST) begin
            rst_pend    = 1;
            outstanding = 0;
            out_on      = 0;
            burst_left  = 0;
            pix_n       = 0;
            hold_chk    = 0;
            prev_dsi    = 0;
            exp_smp.delete();
            exp_out.delete();
            eng_buf.delete();
            eng_cnt = -1;
            M_DSO   = 1'b0;
            M_DO    = '0;
        end else begin
            if (rst_pend) begin
                chk("rst_in_ready", IN_READY, 1);
                chk("rst_out_valid", OUT_VALID, 0);
                chk("rst_out_last", OUT_LAST, 0);
                chk("rst_out_data", OUT_DATA, 0);
                chk("rst_m_dsi", M_DSI, 0);
                chk("rst_m_di", M_DI, 0);
                rst_pend = 0;
            end
            chk("in_ready", IN_READY, !outstanding);
            chk("out_valid", OUT_VALID, out_on);
            chk("m_dsi", M_DSI, burst_left > 0);
            if (burst_left > 0 && exp_smp.size() > 0) begin
                s = exp_smp.pop_front();
                chk("m_di", M_DI, s);
            end
            if (hold_chk && OUT_VALID === 1'b1) begin
                chk("hold_data", OUT_DATA, held_d);
                chk("hold_last", OUT_LAST, held_l);
            end
            hold_chk = 0;

            if (M_DSI === 1'b1) begin
                obs_burst.push_back(M_DI);
                if (!prev_dsi) burst_cnt++;
            end
            prev_dsi = (M_DSI === 1'b1);

            if (burst_left > 0) burst_left--;
            if (IN_VALID === 1'b1 && IN_READY === 1'b1) begin
                r = (pix_n / IW) % IH;
                c = pix_n % IW;
                img[r][c] = IN_DATA;
                pix_n = (pix_n + 1) % (IW * IH);
                if (r >= 2 && c >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            win[3*i+j] = img[r-2+i][c-2+j];
                    for (int k = 0; k < 9; k++)
                        exp_smp.push_back(win[k]);
                    exp_out.push_back({(r == IH-1 && c == IW-1),
                                       med9(win)});
                    outstanding = 1;
                    burst_left  = 9;
                end
            end

            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                if (exp_out.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    e = exp_out.pop_front();
                    chk("out_data", OUT_DATA, e[7:0]);
                    chk("out_last", OUT_LAST, e[8]);
                end
                obs_data.push_back(OUT_DATA);
                obs_last.push_back(OUT_LAST === 1'b1);
                if (OUT_LAST === 1'b1) last_cnt++;
                out_on      = 0;
                outstanding = 0;
            end else if (OUT_VALID === 1'b1) begin
                hold_chk = 1;
                held_d   = OUT_DATA;
                held_l   = OUT_LAST;
            end

            M_DSO = 1'b0;
            if (M_DSI === 1'b1) eng_buf.push_back(M_DI);
            if (eng_cnt > 0) begin
                eng_cnt--;
            end else if (eng_cnt == 0) begin
                for (int k = 0; k < 9; k++) eb[k] = eng_buf[k];
                M_DSO   = 1'b1;
                M_DO    = med9(eb);
                eng_cnt = -1;
                out_on  = 1;
                eng_buf.delete();
            end else if (eng_buf.size() == 9) begin
                eng_cnt = $urandom_range(5, 40);
            end else if ($urandom_range(0, 7) == 0) begin
                // Stray strobe while no result is due; must be ignored.
                M_DSO = 1'b1;
                M_DO  = 8'($urandom);
            end
        end
    end

    always begin
        @(posedge CLK);
        #2;
        if (rdy_mode) OUT_READY = ($urandom_range(0, 2) != 0);
    end

    task automatic send_px(input logic [7:0] v);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            IN_VALID = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #2;
        end
        IN_DATA  = v;
        IN_VALID = 1'b1;
        n = 0;
        forever begin
            @(negedge CLK);
            if (abort) return;
            if (IN_READY === 1'b1) break;
            n++;
            if (n > 3000) begin
                fail("input_timeout");
                abort = 1;
                @(posedge CLK);
                #2;
                IN_VALID = 1'b0;
                return;
            end
        end
        @(posedge CLK);
        #2;
        IN_VALID = 1'b0;
    endtask

    task automatic send_frame(input int kind);
        logic [7:0] v;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                if (abort) return;
                if (kind == K_RAMP) v = 8'(4 * r + c);
                else if (kind == K_FF) v = 8'hFF;
                else if (kind == K_IMP)
                    v = (r == 1 && c == 1) ? 8'hFF : 8'h20;
                else v = 8'($urandom);
                send_px(v);
            end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((outstanding || out_on || exp_out.size() != 0)
               && n < 3000) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 3000) fail("drain_timeout");
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        obs_burst.delete();
        burst_cnt = 0;
        last_cnt  = 0;
    endtask

    task automatic chk_obs4(input string name, input int base,
                            input logic [7:0] ex [4]);
        for (int i = 0; i < 4; i++) begin
            if (base + i < obs_data.size())
                chk($sformatf("%s[%0d]", name, i), obs_data[base+i], ex[i]);
            else
                fail($sformatf("%s[%0d]", name, i));
        end
    endtask

    task automatic chk_last4(input string name, input int base);
        for (int i = 0; i < 4; i++) begin
            if (base + i < obs_last.size())
                chk($sformatf("%s[%0d]", name, i),
                    obs_last[base+i], i == 3);
            else
                fail($sformatf("%s[%0d]", name, i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        #2;
        nRST = 1'b1;

        // Ramp frame, border skipping and burst order
        clear_obs();
        send_frame(K_RAMP);
        wait_drain();
        chk("ramp_count", obs_data.size(), 4);
        chk_obs4("ramp_out", 0, ramp_exp);
        chk_last4("ramp_last", 0);
        for (int i = 0; i < 9; i++) begin
            if (i < obs_burst.size())
                chk($sformatf("burst0[%0d]", i), obs_burst[i], burst0[i]);
            else
                fail($sformatf("burst0[%0d]", i));
        end
        chk("ramp_bursts", burst_cnt, 4);
        chk("ramp_strobes", obs_burst.size(), 36);
        chk("ramp_lasts", last_cnt, 1);

        // Backpressure on the first result
        clear_obs();
        OUT_READY = 1'b0;
        fork
            send_frame(K_RAMP);
            begin
                n = 0;
                while (OUT_VALID !== 1'b1 && n < 1000) begin
                    @(negedge CLK);
                    n++;
                end
                if (n >= 1000) fail("bp_wait_valid");
                repeat (20) begin
                    @(negedge CLK);
                    chk("bp_hold_data", OUT_DATA, 8'd5);
                    chk("bp_in_ready", IN_READY, 0);
                end
                @(posedge CLK);
                #2;
                OUT_READY = 1'b1;
            end
        join
        wait_drain();
        chk_obs4("bp_out", 0, ramp_exp);

        // Reset in the middle of the first burst
        clear_obs();
        fork
            send_frame(K_RAMP);
            begin
                n = 0;
                while (M_DSI !== 1'b1 && n < 1000) begin
                    @(negedge CLK);
                    n++;
                end
                if (n >= 1000) fail("rst_wait_burst");
                repeat (4) @(posedge CLK);
                #2;
                nRST     = 1'b0;
                IN_VALID = 1'b0;
                abort    = 1;
                @(posedge CLK);
                #2;
                nRST = 1'b1;
            end
        join
        abort = 0;
        chk("rst_no_output", obs_data.size(), 0);
        clear_obs();
        send_frame(K_RAMP);
        wait_drain();
        chk_obs4("rst_ramp", 0, ramp_exp);

        // Back-to-back frames
        clear_obs();
        send_frame(K_FF);
        send_frame(K_RAMP);
        wait_drain();
        chk("b2b_count", obs_data.size(), 8);
        chk_obs4("b2b_ff", 0, ff_exp);
        chk_obs4("b2b_ramp", 4, ramp_exp);
        chk_last4("b2b_last1", 0);
        chk_last4("b2b_last2", 4);
        chk("b2b_lasts", last_cnt, 2);
        chk("b2b_bursts", burst_cnt, 8);

        // Impulse noise is rejected
        clear_obs();
        send_frame(K_IMP);
        wait_drain();
        chk_obs4("impulse", 0, imp_exp);

        // Randomized pixels, input gaps and output stalls
        clear_obs();
        gaps     = 1;
        rdy_mode = 1;
        repeat (6) send_frame(K_RND);
        wait_drain();
        rdy_mode  = 0;
        gaps      = 0;
        OUT_READY = 1'b1;
        chk("rnd_count", obs_data.size(), 24);
        chk("rnd_lasts", last_cnt, 6);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
